// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: EX operand select codes
// and the default register address width.
package hazard_forward_unit_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_mul_scoreboard.sv
// Tracks the single in-flight multiply: countdown to writeback, its
// destination register, a busy flag and a done pulse aligned to the write.
module hazard_forward_unit_mul_scoreboard
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] rd
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (issue)            cnt_next = CNT_W'(MUL_LATENCY);
    else if (cnt != '0)   cnt_next = cnt - 1'b1;
  end

  // done is registered from the next count so it is high exactly while cnt==1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      rd   <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      done <= (cnt_next == CNT_W'(1));
      if (issue) rd <= dst;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Combined EX forwarding, load-use / branch-in-ID / multiplier hazard
// detection and branch flush control for the 5-stage pipeline.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_is_mul,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [REG_AW-1:0] mul_rd
);

  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][REG_AW-1:0] ex_src;
  logic [NUM_OPS-1:0][1:0]        fwd;

  assign ex_src = {ex_rt, ex_rs};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    logic [1:0] sel;
    always_comb begin
      sel = FWD_RF;
      if (mem_reg_write && mem_rd != '0 && mem_rd == ex_src[i])     sel = FWD_MEM;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_src[i])   sel = FWD_WB;
    end
    assign fwd[i] = sel;
  end

  assign forward_a = rst ? FWD_RF : fwd[0];
  assign forward_b = rst ? FWD_RF : fwd[1];

  function automatic logic rd_hit(input logic [REG_AW-1:0] r,
                                  input logic [REG_AW-1:0] rs,
                                  input logic [REG_AW-1:0] rt,
                                  input logic              use_rs,
                                  input logic              use_rt);
    return (r != '0) && ((use_rs && rs == r) || (use_rt && rt == r));
  endfunction

  logic hit_ex, hit_mem, hit_mul;
  logic load_use, branch_hz, mul_hz, stall, issue;

  assign hit_ex  = rd_hit(ex_rd,  id_rs, id_rt, id_use_rs, id_use_rt);
  assign hit_mem = rd_hit(mem_rd, id_rs, id_rt, id_use_rs, id_use_rt);
  assign hit_mul = rd_hit(mul_rd, id_rs, id_rt, id_use_rs, id_use_rt);

  assign load_use  = ex_mem_read & hit_ex;
  assign branch_hz = id_branch & ((ex_reg_write & hit_ex) | (mem_mem_read & hit_mem));
  // RAW on the mul result, structural (one mul in flight), and WAW on its dst
  assign mul_hz    = mul_busy & (hit_mul | id_is_mul | (id_dst == mul_rd && id_dst != '0));
  assign stall     = load_use | branch_hz | mul_hz;
  assign issue     = id_is_mul & ~stall & ~rst;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst || stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush  = branch_taken & id_branch;
    end
  end

  hazard_forward_unit_mul_scoreboard #(
    .REG_AW      (REG_AW),
    .MUL_LATENCY (MUL_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mul_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .dst   (id_dst),
    .busy  (mul_busy),
    .done  (mul_done),
    .rd    (mul_rd)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed pipeline scenarios plus random traffic, all checked every cycle
// against a reference model that tracks the mul by its issue cycle.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  localparam int AW  = 5;
  localparam int LAT = 4;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs, id_rt;
    logic          use_rs, use_rt, branch, is_mul;
    logic [AW-1:0] id_dst;
    logic          taken;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic          ex_rw, ex_mr;
    logic [AW-1:0] mem_rd;
    logic          mem_rw, mem_mr;
    logic [AW-1:0] wb_rd;
    logic          wb_rw;
  } stim_t;

  logic clk = 1'b0;
  stim_t s;
  logic [1:0]    forward_a, forward_b;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic          mul_busy, mul_done;
  logic [AW-1:0] mul_rd;

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(AW), .MUL_LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(s.rst),
    .id_rs(s.id_rs), .id_rt(s.id_rt), .id_use_rs(s.use_rs), .id_use_rt(s.use_rt),
    .id_branch(s.branch), .id_is_mul(s.is_mul), .id_dst(s.id_dst), .branch_taken(s.taken),
    .ex_rs(s.ex_rs), .ex_rt(s.ex_rt), .ex_rd(s.ex_rd),
    .ex_reg_write(s.ex_rw), .ex_mem_read(s.ex_mr),
    .mem_rd(s.mem_rd), .mem_reg_write(s.mem_rw), .mem_mem_read(s.mem_mr),
    .wb_rd(s.wb_rd), .wb_reg_write(s.wb_rw),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_rd(mul_rd)
  );

  int checks = 0, passed = 0;
  int cyc = 0, iss = -1000;
  logic [AW-1:0] m_rd = '0;
  logic pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic reads(input stim_t t, input logic [AW-1:0] r);
    return r != 0 && ((t.use_rs && t.id_rs == r) || (t.use_rt && t.id_rt == r));
  endfunction

  function automatic logic [1:0] fwd_of(input stim_t t, input logic [AW-1:0] src);
    if (t.mem_rw && t.mem_rd != 0 && t.mem_rd == src) return 2'b10;
    if (t.wb_rw && t.wb_rd != 0 && t.wb_rd == src)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_now();
    logic busy, done, stall;
    busy  = cyc > iss && cyc <= iss + LAT;
    done  = cyc == iss + LAT;
    stall = (s.ex_mr && reads(s, s.ex_rd))
         || (s.branch && ((s.ex_rw && reads(s, s.ex_rd)) || (s.mem_mr && reads(s, s.mem_rd))))
         || (busy && (reads(s, m_rd) || s.is_mul || (s.id_dst == m_rd && s.id_dst != 0)));
    pend = !s.rst && s.is_mul && !stall;
    if (s.rst) begin
      chk("rst_fwd_a", forward_a, 0);
      chk("rst_fwd_b", forward_b, 0);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_if_id_write", if_id_write, 0);
      chk("rst_bubble", id_ex_bubble, 1);
      chk("rst_flush", if_id_flush, 0);
    end else begin
      chk("fwd_a", forward_a, fwd_of(s, s.ex_rs));
      chk("fwd_b", forward_b, fwd_of(s, s.ex_rt));
      chk("pc_write", pc_write, !stall);
      chk("if_id_write", if_id_write, !stall);
      chk("bubble", id_ex_bubble, stall);
      chk("flush", if_id_flush, s.branch && s.taken && !stall);
    end
    chk("mul_busy", mul_busy, busy);
    chk("mul_done", mul_done, done);
    chk("mul_rd", mul_rd, m_rd);
  endtask

  task automatic tick(input stim_t n);
    @(posedge clk);
    if (s.rst) begin iss = -1000; m_rd = '0; end
    else if (pend) begin iss = cyc; m_rd = s.id_dst; end
    cyc++;
    #1 s = n;
    if (n.rst) begin iss = -1000; m_rd = '0; end
    @(negedge clk);
    check_now();
  endtask

  function automatic stim_t rnd();
    stim_t t;
    t = '0;
    t.rst    = ($urandom_range(0, 63) == 0);
    t.id_rs  = AW'($urandom_range(0, 3)); t.id_rt = AW'($urandom_range(0, 3));
    t.use_rs = 1'($urandom); t.use_rt = 1'($urandom);
    t.branch = ($urandom_range(0, 3) == 0); t.taken = 1'($urandom);
    t.is_mul = ($urandom_range(0, 3) == 0); t.id_dst = AW'($urandom_range(0, 3));
    t.ex_rs  = AW'($urandom_range(0, 3)); t.ex_rt = AW'($urandom_range(0, 3));
    t.ex_rd  = AW'($urandom_range(0, 3));
    t.ex_rw  = 1'($urandom); t.ex_mr = ($urandom_range(0, 3) == 0);
    t.mem_rd = AW'($urandom_range(0, 3));
    t.mem_rw = 1'($urandom); t.mem_mr = ($urandom_range(0, 3) == 0);
    t.wb_rd  = AW'($urandom_range(0, 3)); t.wb_rw = 1'($urandom);
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    stim_t t;
    int stalls, done_at;
    s = '0; s.rst = 1'b1;
    @(negedge clk); check_now();
    t = '0; t.rst = 1'b1; tick(t);
    t = '0; tick(t);

    // forwarding priority and r0 exclusion
    t = '0; t.mem_rw = 1; t.mem_rd = 3; t.wb_rw = 1; t.wb_rd = 3; t.ex_rs = 3;
    tick(t); chk("fwd_mem_wins", forward_a, 2'b10);
    t.mem_rd = 0; t.ex_rs = 0;
    tick(t); chk("fwd_r0", forward_a, 2'b00);

    // load-use: one stall, then WB forward
    t = '0; t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 2; t.use_rs = 1; t.id_rs = 2;
    tick(t); chk("lu_stall", pc_write, 0);
    t = '0; t.mem_mr = 1; t.mem_rw = 1; t.mem_rd = 2; t.use_rs = 1; t.id_rs = 2;
    tick(t); chk("lu_release", pc_write, 1);
    t = '0; t.wb_rw = 1; t.wb_rd = 2; t.ex_rs = 2;
    tick(t); chk("lu_fwd_wb", forward_a, 2'b01);

    // branch after load: two stalls, flush only once released
    t = '0; t.branch = 1; t.taken = 1; t.use_rs = 1; t.id_rs = 4;
    t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 4;
    tick(t); chk("br_lw_stall1", pc_write, 0); chk("br_lw_noflush1", if_id_flush, 0);
    t.ex_mr = 0; t.ex_rw = 0; t.ex_rd = 0; t.mem_mr = 1; t.mem_rw = 1; t.mem_rd = 4;
    tick(t); chk("br_lw_stall2", pc_write, 0); chk("br_lw_noflush2", if_id_flush, 0);
    t.mem_mr = 0; t.mem_rw = 0; t.mem_rd = 0; t.wb_rw = 1; t.wb_rd = 4;
    tick(t); chk("br_lw_go", pc_write, 1); chk("br_lw_flush", if_id_flush, 1);

    // branch after ALU op: one stall
    t = '0; t.branch = 1; t.taken = 1; t.use_rt = 1; t.id_rt = 4; t.ex_rw = 1; t.ex_rd = 4;
    tick(t); chk("br_alu_stall", pc_write, 0);
    t.ex_rw = 0; t.ex_rd = 0; t.mem_rw = 1; t.mem_rd = 4;
    tick(t); chk("br_alu_flush", if_id_flush, 1);

    // mul r5 then reader of r5
    t = '0; t.is_mul = 1; t.id_dst = 5; tick(t);
    t = '0; t.use_rs = 1; t.id_rs = 5;
    stalls = 0; done_at = 0;
    for (int i = 0; i < 12; i++) begin
      tick(t);
      if (mul_done) done_at = i + 1;
      if (pc_write) break;
      stalls++;
    end
    chk("mul_raw_stalls", stalls, LAT);
    chk("mul_done_cycle", done_at, LAT);

    // second mul while busy
    t = '0; t.is_mul = 1; t.id_dst = 6; tick(t);
    t.id_dst = 7; stalls = 0;
    for (int i = 0; i < 12; i++) begin
      tick(t);
      if (pc_write) break;
      stalls++;
    end
    chk("mul_struct_stalls", stalls, LAT);
    t = '0;
    for (int i = 0; i < LAT; i++) tick(t);

    // mul to r0 never blocks a reader of r0
    t = '0; t.is_mul = 1; t.id_dst = 0; tick(t);
    t = '0; t.use_rs = 1; t.id_rs = 0; tick(t);
    chk("mul_r0_nostall", pc_write, 1);
    t = '0;
    for (int i = 0; i < LAT; i++) tick(t);

    // async reset mid-mul: asserted while the count sits at 2
    t = '0; t.is_mul = 1; t.id_dst = 9; tick(t);
    t = '0; tick(t); tick(t);
    t.rst = 1; tick(t);
    chk("rst_busy_clear", mul_busy, 0);
    t = '0;
    for (int i = 0; i < LAT; i++) begin
      tick(t);
      chk("rst_no_done", mul_done, 0);
    end

    for (int i = 0; i < 2000; i++) tick(rnd());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
